// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the bundle of decoded timing flags that travels
// down the sync/colour alignment pipeline.
package vga_pkg;

  localparam int unsigned ClksPerPixel = 4;
  localparam int unsigned HVisible     = 640;
  localparam int unsigned HFront       = 16;
  localparam int unsigned HSync        = 96;
  localparam int unsigned HBack        = 48;
  localparam int unsigned VVisible     = 480;
  localparam int unsigned VFront       = 10;
  localparam int unsigned VSync        = 2;
  localparam int unsigned VBack        = 33;
  localparam int unsigned PipePixels   = 2;

  localparam int unsigned HTotal     = HVisible + HFront + HSync + HBack;
  localparam int unsigned VTotal     = VVisible + VFront + VSync + VBack;
  localparam int unsigned HSyncStart = HVisible + HFront;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync - 1;
  localparam int unsigned VSyncStart = VVisible + VFront;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync - 1;

  localparam int unsigned RgbW  = 8;
  localparam int unsigned HCntW = 10;
  localparam int unsigned VCntW = 10;
  localparam int unsigned RowW  = 9;

  // first marks raster position (0,0) so frame_start can be aligned with the pixels.
  typedef struct packed {
    logic first;
    logic active;
    logic hs;
    logic vs;
  } sync_t;

  function automatic logic in_window(input logic [HCntW-1:0] cnt, input int unsigned lo,
                                     input int unsigned hi);
    return (cnt >= HCntW'(lo)) && (cnt <= HCntW'(hi));
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-rate shift register that delays the decoded timing flags so sync and blanking line up
// with the colour returned by the pixel generator.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en_i,
  input  sync_t sync_i,
  output sync_t sync_o,
  output sync_t sync_next_o
);

  sync_t stage_q [Depth];
  sync_t stage_d [Depth];

  always_comb begin
    for (int i = 0; i < Depth; i++) stage_d[i] = stage_q[i];
    if (en_i) begin
      stage_d[0] = sync_i;
      for (int i = 1; i < Depth; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign sync_o = stage_q[Depth-1];

  // sync_next_o is the value the last stage loads at the next pixel boundary.
  if (Depth > 1) begin : g_deep
    assign sync_next_o = stage_q[Depth-2];
  end else begin : g_single
    assign sync_next_o = sync_i;
  end

endmodule

// File: rtl/vga_timing_controller.sv
// Free-running VGA raster: issues per-pixel requests to the pixel generator and drives the
// sync/colour pins with the generator latency absorbed by a matching sync delay.
module vga_timing_controller
  import vga_pkg::*;
#(
  parameter int unsigned CLKS_PER_PIXEL = ClksPerPixel,
  parameter int unsigned H_VISIBLE      = HVisible,
  parameter int unsigned H_FRONT        = HFront,
  parameter int unsigned H_SYNC         = HSync,
  parameter int unsigned H_BACK         = HBack,
  parameter int unsigned V_VISIBLE      = VVisible,
  parameter int unsigned V_FRONT        = VFront,
  parameter int unsigned V_SYNC         = VSync,
  parameter int unsigned V_BACK         = VBack,
  parameter int unsigned PIPE_PIXELS    = PipePixels
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RgbW-1:0]  pixel_data,
  output logic             req,
  output logic [RowW-1:0]  row,
  output logic [HCntW-1:0] column,
  output logic             hsync,
  output logic             vsync,
  output logic [RgbW-1:0]  vga_rgb,
  output logic             display_en,
  output logic             frame_start
);

  localparam int unsigned TickW    = $clog2(CLKS_PER_PIXEL);
  localparam int unsigned LineLen  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned FrameLen = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HsStart  = H_VISIBLE + H_FRONT;
  localparam int unsigned HsEnd    = HsStart + H_SYNC - 1;
  localparam int unsigned VsStart  = V_VISIBLE + V_FRONT;
  localparam int unsigned VsEnd    = VsStart + V_SYNC - 1;

  logic [TickW-1:0] tick_q, tick_d;
  logic [HCntW-1:0] h_q, h_d;
  logic [VCntW-1:0] v_q, v_d;
  logic             req_q, req_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [HCntW-1:0] column_q, column_d;
  logic [RgbW-1:0]  rgb_q, rgb_d;
  logic             frame_start_q, frame_start_d;
  logic             pix_end;
  sync_t            sync_cur, sync_q, sync_next;

  assign pix_end = (tick_q == TickW'(CLKS_PER_PIXEL - 1));

  always_comb begin
    tick_d = tick_q + TickW'(1);
    h_d    = h_q;
    v_d    = v_q;
    if (pix_end) begin
      tick_d = '0;
      if (h_q == HCntW'(LineLen - 1)) begin
        h_d = '0;
        v_d = (v_q == VCntW'(FrameLen - 1)) ? '0 : v_q + VCntW'(1);
      end else begin
        h_d = h_q + HCntW'(1);
      end
    end
  end

  always_comb begin
    sync_cur.first  = (h_q == '0) && (v_q == '0);
    sync_cur.active = (h_q < HCntW'(H_VISIBLE)) && (v_q < VCntW'(V_VISIBLE));
    sync_cur.hs     = in_window(h_q, HsStart, HsEnd);
    sync_cur.vs     = in_window(v_q, VsStart, VsEnd);
  end

  // Requests run through blanking too, keeping the generator's fetch sequence in step.
  always_comb begin
    req_d    = (tick_q == '0);
    row_d    = row_q;
    column_d = column_q;
    if (req_d) begin
      row_d    = v_q[RowW-1:0];
      column_d = h_q;
    end
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    if (pix_end) begin
      rgb_d         = sync_next.active ? pixel_data : '0;
      frame_start_d = sync_next.first;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q        <= '0;
      h_q           <= '0;
      v_q           <= '0;
      req_q         <= 1'b0;
      row_q         <= '0;
      column_q      <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      h_q           <= h_d;
      v_q           <= v_d;
      req_q         <= req_d;
      row_q         <= row_d;
      column_q      <= column_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  vga_sync_delay #(
    .Depth(PIPE_PIXELS)
  ) u_sync_delay (
    .clk        (clk),
    .reset      (reset),
    .en_i       (pix_end),
    .sync_i     (sync_cur),
    .sync_o     (sync_q),
    .sync_next_o(sync_next)
  );

  logic unused_sync;
  assign unused_sync = ^{sync_next.hs, sync_next.vs, sync_q.first};

  assign req         = req_q;
  assign row         = row_q;
  assign column      = column_q;
  assign hsync       = ~sync_q.hs;
  assign vsync       = ~sync_q.vs;
  assign vga_rgb     = rgb_q;
  assign display_en  = sync_q.active;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench: a reduced raster (random/echo generator, random mid-frame resets) and a full-size
// 640x480 instance, both compared every cycle against a closed-form raster model.
module tb_vga_timing_controller;

  localparam int SC = 5, SHV = 20, SHF = 3, SHS = 5, SHB = 4;
  localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int DC = 4, DHV = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;
  localparam int PIPE = 2;
  localparam int NCYC = 9000;

  logic clk = 1'b0;
  logic rst_s, rst_d;
  logic [7:0] pd_s, pd_d;
  logic s_req, s_hsync, s_vsync, s_display_en, s_frame_start;
  logic [8:0] s_row;
  logic [9:0] s_column;
  logic [7:0] s_vga_rgb;
  logic d_req, d_hsync, d_vsync, d_display_en, d_frame_start;
  logic [8:0] d_row;
  logic [9:0] d_column;
  logic [7:0] d_vga_rgb;

  always #5 clk = ~clk;

  vga_timing_controller #(
    .CLKS_PER_PIXEL(SC), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .PIPE_PIXELS(PIPE)
  ) dut_s (
    .clk(clk), .reset(rst_s), .pixel_data(pd_s), .req(s_req), .row(s_row),
    .column(s_column), .hsync(s_hsync), .vsync(s_vsync), .vga_rgb(s_vga_rgb),
    .display_en(s_display_en), .frame_start(s_frame_start)
  );

  vga_timing_controller dut_d (
    .clk(clk), .reset(rst_d), .pixel_data(pd_d), .req(d_req), .row(d_row),
    .column(d_column), .hsync(d_hsync), .vsync(d_vsync), .vga_rgb(d_vga_rgb),
    .display_en(d_display_en), .frame_start(d_frame_start)
  );

  int n_tests = 0;
  int n_fail = 0;
  int k_s, k_d;
  logic [7:0] ring [8];
  logic [7:0] stash;
  bit echo;

  typedef struct {
    int req, row, col, hsync, vsync, en, fs, pos;
  } exp_t;

  // k = clock edges since reset release. Request for pixel period p is registered at the
  // first edge of p; the position shown after the edge ending period q is q-PIPE+1.
  function automatic exp_t model(int k, int c, int hv, int hf, int hs, int hb,
                                 int vv, int vf, int vsw, int vb);
    exp_t e;
    int ht, vt, p, kb, h, v;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vsw + vb;
    e.req = 0; e.row = 0; e.col = 0; e.hsync = 1; e.vsync = 1; e.en = 0; e.fs = 0;
    e.pos = -1;
    if (k == 0) return e;
    p = (k - 1) / c;
    e.req = ((k - 1) % c == 0) ? 1 : 0;
    e.row = ((p / ht) % vt) % 512;
    e.col = p % ht;
    kb = (k / c) * c;
    e.pos = kb / c - PIPE;
    if (kb > 0 && e.pos >= 0) begin
      h = e.pos % ht;
      v = (e.pos / ht) % vt;
      e.en = (h < hv && v < vv) ? 1 : 0;
      e.hsync = (h >= hv + hf && h < hv + hf + hs) ? 0 : 1;
      e.vsync = (v >= vv + vf && v < vv + vf + vsw) ? 0 : 1;
      e.fs = (k == kb && h == 0 && v == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv, input int k);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, k);
    end
  endtask

  task automatic cmp_small();
    exp_t e;
    int rgb;
    e = model(k_s, SC, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
    rgb = (e.en == 1) ? int'(ring[e.pos % 8]) : 0;
    chk("s_req", int'(s_req), e.req, k_s);
    chk("s_row", int'(s_row), e.row, k_s);
    chk("s_column", int'(s_column), e.col, k_s);
    chk("s_hsync", int'(s_hsync), e.hsync, k_s);
    chk("s_vsync", int'(s_vsync), e.vsync, k_s);
    chk("s_display_en", int'(s_display_en), e.en, k_s);
    chk("s_frame_start", int'(s_frame_start), e.fs, k_s);
    chk("s_vga_rgb", int'(s_vga_rgb), rgb, k_s);
  endtask

  task automatic cmp_default();
    exp_t e;
    e = model(k_d, DC, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB);
    chk("d_req", int'(d_req), e.req, k_d);
    chk("d_row", int'(d_row), e.row, k_d);
    chk("d_column", int'(d_column), e.col, k_d);
    chk("d_hsync", int'(d_hsync), e.hsync, k_d);
    chk("d_vsync", int'(d_vsync), e.vsync, k_d);
    chk("d_display_en", int'(d_display_en), e.en, k_d);
    chk("d_frame_start", int'(d_frame_start), e.fs, k_d);
    chk("d_vga_rgb", int'(d_vga_rgb), (e.en == 1) ? 255 : 0, k_d);
  endtask

  initial begin
    int p, rst_hold, fall1, fall2, rise1, en_cnt, fs1, fs2, en_rise1;
    bit had_reset, prev_hs_d;
    logic [7:0] dat;
    rst_s = 1'b1; rst_d = 1'b1; pd_s = '0; pd_d = 8'hFF; stash = '0; echo = 1'b0;
    k_s = 0; k_d = 0; rst_hold = 0; had_reset = 1'b0; prev_hs_d = 1'b1;
    fall1 = -1; fall2 = -1; rise1 = -1; en_cnt = 0; fs1 = -1; fs2 = -1; en_rise1 = -1;
    for (int i = 0; i < 8; i++) ring[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp_small();
    cmp_default();
    #2;
    rst_s = 1'b0;
    rst_d = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (!rst_s) k_s++;
      k_d++;
      echo = ((cyc / 1500) % 2) == 1;
      cmp_small();
      cmp_default();

      if (!rst_s && s_req) begin
        p = (k_s - 1) / SC;
        dat = echo ? s_column[7:0] : 8'($urandom);
        ring[p % 8] = echo ? 8'(p % SHT) : dat;
        pd_s = stash;
        stash = dat;
      end

      if (prev_hs_d && !d_hsync) begin
        if (fall1 < 0) fall1 = k_d;
        else if (fall2 < 0) fall2 = k_d;
      end
      if (!prev_hs_d && d_hsync && fall1 >= 0 && rise1 < 0) rise1 = k_d;
      if (fall1 >= 0 && fall2 < 0 && d_display_en) en_cnt++;
      prev_hs_d = d_hsync;

      if (!had_reset && s_frame_start) begin
        if (fs1 < 0) fs1 = k_s;
        else if (fs2 < 0) fs2 = k_s;
      end
      if (!had_reset && s_display_en && en_rise1 < 0) en_rise1 = k_s;

      if (rst_s) begin
        rst_hold--;
        if (rst_hold == 0) begin
          #2;
          rst_s = 1'b0;
          k_s = 0;
        end
      end else if (cyc == 6000 || (cyc > 6500 && $urandom_range(0, 699) == 0)) begin
        #2;
        rst_s = 1'b1;
        k_s = 0;
        had_reset = 1'b1;
        rst_hold = $urandom_range(1, 3);
        #1;
        cmp_small();
      end
    end

    chk("d_first_hsync_fall", fall1, 2632, k_d);
    chk("d_hsync_period", fall2 - fall1, 3200, k_d);
    chk("d_hsync_low_width", rise1 - fall1, 384, k_d);
    chk("d_visible_clks_per_line", en_cnt, 2560, k_d);
    chk("s_first_display_en", en_rise1, 10, k_s);
    chk("s_first_frame_start", fs1, 10, k_s);
    chk("s_frame_period", fs2 - fs1, 2080, k_s);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
